riscv_mult_iter: RTL and testbench

Parametrised iterative multiplier for the EX stage, the multi-cycle successor to the single-op multiply path. Executes the `mul_op_t` operations MUL_I, MUL_H (signed/unsigned variants), MAC32 and MSU32 on WIDTH-bit operands. It retires BITS_PER_CYCLE multiplier bits per cycle using a shift-add datapath with a 2·WIDTH-bit product. A valid/ready handshake sits on both input and output, and a kill input aborts the operation.

---
 rtl/riscv_mult_iter.sv | 186 ++++++++++++++++++
 tb/tb_riscv_mult_iter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mult_iter.sv
// Iterative shift-add multiplier for EX: MUL_I, MUL_H, MAC32, MSU32.
// Optional MULT_EARLY_TERM_EN: leave CALC once the multiplier is exhausted.
package riscv_mult_pkg;
  typedef enum logic [2:0] {
    MUL_MAC32 = 3'd0,
    MUL_MSU32 = 3'd1,
    MUL_I     = 3'd2,
    MUL_IR    = 3'd3,
    MUL_DOT8  = 3'd4,
    MUL_DOT16 = 3'd5,
    MUL_H     = 3'd6
  } mul_op_t;
endpackage

module riscv_mult_iter
  import riscv_mult_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic             ready_o,
  input  logic [2:0]       operator_i,
  input  logic [1:0]       short_signed_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [WIDTH-1:0] op_c_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_CALC, S_FINISH, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] opc_q, opc_d;
  mul_op_t          op_q, op_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;

  mul_op_t          op_in;
  logic             supported;
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    prod_s;
  logic             calc_last;

  assign op_in = mul_op_t'(operator_i);

  always_comb begin
    supported = 1'b0;
    sgn_a     = op_a_i[WIDTH-1];
    sgn_b     = op_b_i[WIDTH-1];
    unique case (op_in)
      MUL_I, MUL_MAC32, MUL_MSU32: supported = 1'b1;
      MUL_H: begin
        supported = 1'b1;
        sgn_a     = short_signed_i[1] & op_a_i[WIDTH-1];
        sgn_b     = short_signed_i[0] & op_b_i[WIDTH-1];
      end
      default: supported = 1'b0;
    endcase
    // -2^(W-1) negates to itself, which is already the right magnitude
    mag_a = sgn_a ? (WIDTH'(0) - op_a_i) : op_a_i;
    mag_b = sgn_b ? (WIDTH'(0) - op_b_i) : op_b_i;
  end

  always_comb begin
    pp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    end
  end

  assign prod_s = sign_q ? (PW'(0) - prod_q) : prod_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    opc_d     = opc_q;
    op_d      = op_q;
    sign_d    = sign_q;
    res_d     = res_q;
    err_d     = err_q;
    calc_last = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en_i) begin
          if (supported) begin
            state_d  = S_CALC;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
            prod_d   = '0;
            opc_d    = op_c_i;
            op_d     = op_in;
            sign_d   = sgn_a ^ sgn_b;
          end else begin
            state_d = S_DONE;
            res_d   = '0;
            err_d   = 1'b1;
          end
        end
      end
      S_CALC: begin
        prod_d   = prod_q + pp;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + 1'b1;
`ifdef MULT_EARLY_TERM_EN
        calc_last = (cnt_q == LAST) || (mplier_d == '0);
`else
        calc_last = (cnt_q == LAST);
`endif
        if (calc_last) state_d = S_FINISH;
      end
      S_FINISH: begin
        err_d   = 1'b0;
        state_d = S_DONE;
        case (op_q)
          MUL_H:     res_d = prod_s[PW-1:WIDTH];
          MUL_MAC32: res_d = opc_q + prod_s[WIDTH-1:0];
          MUL_MSU32: res_d = opc_q - prod_s[WIDTH-1:0];
          default:   res_d = prod_s[WIDTH-1:0];
        endcase
      end
      S_DONE: begin
        if (ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      opc_q    <= '0;
      op_q     <= MUL_MAC32;
      sign_q   <= 1'b0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      opc_q    <= opc_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE) & ~rst;
  assign valid_o  = (state_q == S_DONE);
  assign result_o = valid_o ? res_q : '0;
  assign err_o    = valid_o & err_q;

endmodule

// File: tb/tb_riscv_mult_iter.sv
// Directed bench for riscv_mult_iter (WIDTH=32, B=2).
// Latency expectations follow MULT_EARLY_TERM_EN when defined.
module tb_riscv_mult_iter;
  import riscv_mult_pkg::*;

  localparam int W = 32;
  localparam int B = 2;
  localparam int N = W / B;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en_i = 1'b0;
  logic         ready_o;
  logic [2:0]   operator_i = '0;
  logic [1:0]   short_signed_i = '0;
  logic [W-1:0] op_a_i = '0;
  logic [W-1:0] op_b_i = '0;
  logic [W-1:0] op_c_i = '0;
  logic         kill_i = 1'b0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [W-1:0] result_o;
  logic         err_o;

  int n_chk = 0;
  int n_pass = 0;

  riscv_mult_iter #(.WIDTH(W), .BITS_PER_CYCLE(B)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .ready_o(ready_o),
    .operator_i(operator_i), .short_signed_i(short_signed_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .op_c_i(op_c_i),
    .kill_i(kill_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int lat_of(input logic [31:0] mb);
    int bl;
    int c;
    bl = 0;
    c  = N;
    for (int i = 0; i < W; i++) if (mb[i]) bl = i + 1;
`ifdef MULT_EARLY_TERM_EN
    c = (bl + B - 1) / B;
    if (c < 1) c = 1;
`endif
    if (bl < 0) c = 0;
    return c + 2;
  endfunction

  task automatic start(input logic [2:0] op, input logic [1:0] ss,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    @(negedge clk);
    operator_i = op;
    short_signed_i = ss;
    op_a_i = a;
    op_b_i = b;
    op_c_i = c;
    en_i = 1'b1;
    @(posedge clk);
    #1;
    en_i = 1'b0;
    op_a_i = 32'h1234_5678;
    op_b_i = 32'h0F0F_0F0F;
    op_c_i = 32'hDEAD_BEEF;
  endtask

  task automatic wait_valid(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      seen = valid_o;
    end
  endtask

  task automatic release_res(input string tag);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk({tag, ".valid_after"}, 32'(valid_o), 32'd0);
    chk({tag, ".ready_after"}, 32'(ready_o), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [1:0] ss, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] exp, input logic [31:0] mb);
    int cyc;
    start(op, ss, a, b, c);
    wait_valid(cyc);
    chk({tag, ".lat"}, 32'(cyc), 32'(lat_of(mb)));
    chk({tag, ".res"}, result_o, exp);
    chk({tag, ".err"}, 32'(err_o), 32'd0);
    release_res(tag);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(ready_o), 32'd0);
    chk("rst.valid", 32'(valid_o), 32'd0);
    chk("rst.result", result_o, 32'd0);
    chk("rst.err", 32'(err_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.ready", 32'(ready_o), 32'd1);

    run_op("mul_i", MUL_I, 2'b00, 32'd7, 32'hFFFF_FFFD, 32'd0,
           32'hFFFF_FFEB, 32'd3);
    run_op("mulh", MUL_H, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'd0,
           32'h4000_0000, 32'h8000_0000);
    run_op("mulhu", MUL_H, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
           32'hFFFF_FFFE, 32'hFFFF_FFFF);
    run_op("mulhsu", MUL_H, 2'b10, 32'hFFFF_FFFF, 32'd2, 32'd0,
           32'hFFFF_FFFF, 32'd2);
    run_op("msu32", MUL_MSU32, 2'b00, 32'd3, 32'd4, 32'd10,
           32'hFFFF_FFFE, 32'd4);

    // MAC32 held in DONE under backpressure with a stray en_i pulse
    start(MUL_MAC32, 2'b00, 32'd3, 32'd4, 32'd10);
    wait_valid(cyc);
    chk("mac.lat", 32'(cyc), 32'(lat_of(32'd4)));
    chk("mac.res", result_o, 32'h16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en_i = (i == 2);
      operator_i = MUL_I;
      op_a_i = 32'd5;
      op_b_i = 32'd5;
      chk("bp.valid", 32'(valid_o), 32'd1);
      chk("bp.res", result_o, 32'h16);
      chk("bp.ready", 32'(ready_o), 32'd0);
    end
    en_i = 1'b0;
    release_res("bp");

    // kill in CALC
    start(MUL_I, 2'b00, 32'd7, 32'hFFFF_FFFD, 32'd0);
    repeat (5) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill.ready", 32'(ready_o), 32'd1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= valid_o;
    end
    chk("kill.novalid", 32'(seen), 32'd0);
    run_op("kill.next", MUL_I, 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 32'd3);

    // synchronous reset in CALC
    start(MUL_I, 2'b00, 32'd7, 32'hFFFF_FFFD, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2.ready", 32'(ready_o), 32'd0);
    chk("rst2.valid", 32'(valid_o), 32'd0);
    chk("rst2.result", result_o, 32'd0);
    chk("rst2.err", 32'(err_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2.idle", 32'(ready_o), 32'd1);
    run_op("rst2.next", MUL_I, 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 32'd3);

    // unsupported opcode, then kill and ready together in DONE
    start(MUL_DOT8, 2'b00, 32'd9, 32'd9, 32'd0);
    wait_valid(cyc);
    chk("dot8.lat", 32'(cyc), 32'd1);
    chk("dot8.err", 32'(err_o), 32'd1);
    chk("dot8.res", result_o, 32'd0);
    kill_i = 1'b1;
    ready_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    ready_i = 1'b0;
    chk("dot8.valid_after", 32'(valid_o), 32'd0);
    chk("dot8.ready_after", 32'(ready_o), 32'd1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= valid_o;
    end
    chk("dot8.norepeat", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
